// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: PC register, next-PC selection and IF/ID register.
// Optional fetch/stall performance counters are enabled by FETCH_PERF_CNT_EN.
module instruction_fetch_stage #(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int unsigned IMEM_INDEX_HI = 11,
    localparam int unsigned XLEN         = 32
) (
    input  logic            Clk,
    input  logic            Reset,
    output logic [XLEN-1:0] IMemAddress,
    input  logic [XLEN-1:0] IMemInstruction,
    input  logic            Stall,
    input  logic            Flush,
    input  logic            PCSrc,
    input  logic [XLEN-1:0] BranchTarget,
    input  logic            Jump,
    input  logic [XLEN-1:0] JumpTarget,
    output logic [XLEN-1:0] PC_IF,
    output logic [XLEN-1:0] Instruction_ID,
    output logic [XLEN-1:0] PCPlus4_ID,
    output logic            Valid_ID
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [XLEN-1:0] FetchCount,
    output logic [XLEN-1:0] StallCount
`endif
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] pc_plus4_id_q, pc_plus4_id_d;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] pc_plus4_c;
    logic            redirect_c;
    logic            squash_c;
    logic            capture_c;
`ifdef FETCH_PERF_CNT_EN
    logic [XLEN-1:0] fetch_count_q, fetch_count_d;
    logic [XLEN-1:0] stall_count_q, stall_count_d;
`endif

    // Next-PC selection and IF/ID update; redirects squash the wrong-path word
    always_comb begin
        redirect_c    = Jump | PCSrc;
        squash_c      = redirect_c | Flush;
        capture_c     = !squash_c && !Stall;
        pc_plus4_c    = pc_q + XLEN'(4);
        pc_d          = pc_q;
        instr_d       = instr_q;
        pc_plus4_id_d = pc_plus4_id_q;
        valid_d       = valid_q;

        if (Jump) begin
            pc_d = {JumpTarget[XLEN-1:2], 2'b00};
        end else if (PCSrc) begin
            pc_d = {BranchTarget[XLEN-1:2], 2'b00};
        end else if (!Stall) begin
            pc_d = pc_plus4_c;
        end

        if (squash_c) begin
            instr_d       = '0;
            pc_plus4_id_d = '0;
            valid_d       = 1'b0;
        end else if (capture_c) begin
            instr_d       = IMemInstruction;
            pc_plus4_id_d = pc_plus4_c;
            valid_d       = 1'b1;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Count captured fetches and genuine (non-redirected) stall cycles
    always_comb begin
        fetch_count_d = fetch_count_q + (capture_c ? XLEN'(1) : XLEN'(0));
        stall_count_d = stall_count_q + ((Stall && !squash_c) ? XLEN'(1) : XLEN'(0));
    end
`endif

    // State registers with synchronous active-low reset
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            pc_q          <= {RESET_PC[XLEN-1:2], 2'b00};
            instr_q       <= '0;
            pc_plus4_id_q <= '0;
            valid_q       <= 1'b0;
`ifdef FETCH_PERF_CNT_EN
            fetch_count_q <= '0;
            stall_count_q <= '0;
`endif
        end else begin
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            pc_plus4_id_q <= pc_plus4_id_d;
            valid_q       <= valid_d;
`ifdef FETCH_PERF_CNT_EN
            fetch_count_q <= fetch_count_d;
            stall_count_q <= stall_count_d;
`endif
        end
    end

    // Parameter sanity: word-aligned reset PC and a usable memory index range
    a_params : assert property (@(posedge Clk)
        (RESET_PC[1:0] == 2'b00) && (IMEM_INDEX_HI >= 2) && (IMEM_INDEX_HI < XLEN));

    assign IMemAddress    = pc_q;
    assign PC_IF          = pc_q;
    assign Instruction_ID = instr_q;
    assign PCPlus4_ID     = pc_plus4_id_q;
    assign Valid_ID       = valid_q;
`ifdef FETCH_PERF_CNT_EN
    assign FetchCount     = fetch_count_q;
    assign StallCount     = stall_count_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage; memory word i holds i*3.
module tb_instruction_fetch_stage;

    localparam int unsigned IDX_HI = 11;
    localparam int unsigned NVEC   = 31;

    typedef struct {
        logic        rst_n;
        logic        stall;
        logic        flush;
        logic        pcsrc;
        logic [31:0] bt;
        logic        jump;
        logic [31:0] jt;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic [31:0] e_pc4;
        logic        e_valid;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n, stall, flush, pcsrc, jump;
    logic [31:0] bt, jt;
    logic [31:0] imem_addr, imem_instr, pc_if, instr_id, pc4_id;
    logic        valid_id;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count, stall_count;
`endif

    int errors = 0;
    int checks = 0;
    vec_t vecs [NVEC];

    always #5 clk = ~clk;

    // Combinational instruction memory model
    assign imem_instr = 32'(imem_addr[IDX_HI:2]) * 32'd3;

    instruction_fetch_stage #(.RESET_PC(32'h0), .IMEM_INDEX_HI(IDX_HI)) dut (
        .Clk(clk), .Reset(rst_n), .IMemAddress(imem_addr), .IMemInstruction(imem_instr),
        .Stall(stall), .Flush(flush), .PCSrc(pcsrc), .BranchTarget(bt),
        .Jump(jump), .JumpTarget(jt), .PC_IF(pc_if), .Instruction_ID(instr_id),
        .PCPlus4_ID(pc4_id), .Valid_ID(valid_id)
`ifdef FETCH_PERF_CNT_EN
        , .FetchCount(fetch_count), .StallCount(stall_count)
`endif
    );

    function automatic vec_t mk(logic r, logic s, logic f, logic p, logic [31:0] b,
                                logic j, logic [31:0] t, logic [31:0] epc,
                                logic [31:0] ei, logic [31:0] ep4, logic ev);
        vec_t v;
        v.rst_n = r; v.stall = s; v.flush = f; v.pcsrc = p; v.bt = b;
        v.jump = j; v.jt = t; v.e_pc = epc; v.e_instr = ei; v.e_pc4 = ep4; v.e_valid = ev;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic f, input logic p,
                         input logic [31:0] b, input logic j, input logic [31:0] t);
        @(negedge clk);
        rst_n = r; stall = s; flush = f; pcsrc = p; bt = b; jump = j; jt = t;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input int idx, input logic [31:0] epc, input logic [31:0] ei,
                             input logic [31:0] ep4, input logic ev);
        check($sformatf("pc[%0d]", idx), pc_if, epc);
        check($sformatf("imem_addr[%0d]", idx), imem_addr, epc);
        check($sformatf("instr[%0d]", idx), instr_id, ei);
        check($sformatf("pc4[%0d]", idx), pc4_id, ep4);
        check($sformatf("valid[%0d]", idx), {31'b0, valid_id}, {31'b0, ev});
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0; pcsrc = 1'b0; jump = 1'b0;
        bt = '0; jt = '0;

        //             rst st fl ps bt             jp jt             pc             instr  pc4            v
        vecs[0]  = mk(0, 0, 0, 0, 32'h0,         0, 32'h0,         32'h0,         32'd0,   32'h0,   0);
        vecs[1]  = mk(0, 0, 0, 0, 32'h0,         0, 32'h0,         32'h0,         32'd0,   32'h0,   0);
        vecs[2]  = mk(1, 0, 0, 0, 32'h0,         0, 32'h0,         32'h4,         32'd0,   32'h4,   1);
        vecs[3]  = mk(1, 0, 0, 0, 32'h0,         0, 32'h0,         32'h8,         32'd3,   32'h8,   1);
        vecs[4]  = mk(1, 0, 0, 0, 32'h0,         0, 32'h0,         32'hC,         32'd6,   32'hC,   1);
        vecs[5]  = mk(1, 0, 0, 0, 32'h0,         0, 32'h0,         32'h10,        32'd9,   32'h10,  1);
        vecs[6]  = mk(1, 1, 0, 0, 32'h0,         0, 32'h0,         32'h10,        32'd9,   32'h10,  1);
        vecs[7]  = mk(1, 1, 0, 0, 32'h0,         0, 32'h0,         32'h10,        32'd9,   32'h10,  1);
        vecs[8]  = mk(1, 1, 0, 0, 32'h0,         0, 32'h0,         32'h10,        32'd9,   32'h10,  1);
        vecs[9]  = mk(1, 0, 0, 0, 32'h0,         0, 32'h0,         32'h14,        32'd12,  32'h14,  1);
        vecs[10] = mk(1, 0, 0, 0, 32'h0,         0, 32'h0,         32'h18,        32'd15,  32'h18,  1);
        vecs[11] = mk(1, 0, 0, 0, 32'h0,         0, 32'h0,         32'h1C,        32'd18,  32'h1C,  1);
        vecs[12] = mk(1, 0, 0, 0, 32'h0,         0, 32'h0,         32'h20,        32'd21,  32'h20,  1);
        vecs[13] = mk(1, 0, 0, 1, 32'h43,        0, 32'h0,         32'h40,        32'd0,   32'h0,   0);
        vecs[14] = mk(1, 0, 0, 0, 32'h0,         0, 32'h0,         32'h44,        32'd48,  32'h44,  1);
        vecs[15] = mk(1, 0, 0, 0, 32'h0,         0, 32'h0,         32'h48,        32'd51,  32'h48,  1);
        vecs[16] = mk(1, 0, 0, 1, 32'h40,        1, 32'h80,        32'h80,        32'd0,   32'h0,   0);
        vecs[17] = mk(1, 0, 0, 0, 32'h0,         0, 32'h0,         32'h84,        32'd96,  32'h84,  1);
        vecs[18] = mk(1, 0, 0, 0, 32'h0,         1, 32'h101,       32'h100,       32'd0,   32'h0,   0);
        vecs[19] = mk(1, 0, 0, 0, 32'h0,         0, 32'h0,         32'h104,       32'd192, 32'h104, 1);
        vecs[20] = mk(1, 1, 1, 0, 32'h0,         0, 32'h0,         32'h104,       32'd0,   32'h0,   0);
        vecs[21] = mk(1, 1, 0, 0, 32'h0,         0, 32'h0,         32'h104,       32'd0,   32'h0,   0);
        vecs[22] = mk(1, 0, 1, 0, 32'h0,         0, 32'h0,         32'h108,       32'd0,   32'h0,   0);
        vecs[23] = mk(1, 0, 0, 0, 32'h0,         0, 32'h0,         32'h10C,       32'd198, 32'h10C, 1);
        vecs[24] = mk(0, 1, 0, 1, 32'h300,       1, 32'h200,       32'h0,         32'd0,   32'h0,   0);
        vecs[25] = mk(1, 0, 0, 0, 32'h0,         0, 32'h0,         32'h4,         32'd0,   32'h4,   1);
        vecs[26] = mk(1, 0, 0, 0, 32'h0,         1, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'd0,   32'h0,   0);
        vecs[27] = mk(1, 0, 0, 0, 32'h0,         0, 32'h0,         32'h0,         32'd3069,32'h0,   1);
        vecs[28] = mk(1, 0, 0, 0, 32'h0,         0, 32'h0,         32'h4,         32'd0,   32'h4,   1);
        vecs[29] = mk(1, 1, 0, 1, 32'h12,        0, 32'h0,         32'h10,        32'd0,   32'h0,   0);
        vecs[30] = mk(1, 0, 0, 0, 32'h0,         0, 32'h0,         32'h14,        32'd12,  32'h14,  1);

        for (int i = 0; i < int'(NVEC); i++) begin
            drive(vecs[i].rst_n, vecs[i].stall, vecs[i].flush, vecs[i].pcsrc,
                  vecs[i].bt, vecs[i].jump, vecs[i].jt);
            check_all(i, vecs[i].e_pc, vecs[i].e_instr, vecs[i].e_pc4, vecs[i].e_valid);
        end

        // Long stall holds a valid word, then flush during stall squashes it
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 0, 0, 32'h0, 0, 32'h0);
            check_all(100 + i, 32'h14, 32'd12, 32'h14, 1'b1);
        end
        drive(1, 1, 1, 0, 32'h0, 0, 32'h0);
        check_all(104, 32'h14, 32'd0, 32'h0, 1'b0);
        drive(1, 0, 0, 0, 32'h0, 0, 32'h0);
        check_all(105, 32'h18, 32'd15, 32'h18, 1'b1);

`ifdef FETCH_PERF_CNT_EN
        // Counters: clear, 10 fetches, 3 stalls, clear again
        drive(0, 0, 0, 0, 32'h0, 0, 32'h0);
        drive(0, 0, 0, 0, 32'h0, 0, 32'h0);
        check("fetch_count_rst", fetch_count, 32'd0);
        check("stall_count_rst", stall_count, 32'd0);
        for (int i = 0; i < 10; i++) drive(1, 0, 0, 0, 32'h0, 0, 32'h0);
        for (int i = 0; i < 3; i++)  drive(1, 1, 0, 0, 32'h0, 0, 32'h0);
        drive(1, 1, 0, 1, 32'h0, 0, 32'h0);
        check("fetch_count", fetch_count, 32'd10);
        check("stall_count", stall_count, 32'd3);
        drive(0, 0, 0, 0, 32'h0, 0, 32'h0);
        check("fetch_count_clr", fetch_count, 32'd0);
        check("stall_count_clr", stall_count, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
